// File: rtl/reg_cmd_ctrl.sv
// Byte-command register controller: 0xAA addr data -> register write, 0xBB addr -> register read
// whose data is returned as one TX byte. All outputs registered; errors reported as a one-cycle CMD_ERR pulse.
module reg_cmd_ctrl #(
  parameter int WIDTH   = 8,
  parameter int ADDR    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  input  logic             TX_BUSY,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  output logic             CMD_ERR
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_en_q;
  logic             rd_en_q;
  logic [ADDR-1:0]  addr_q;
  logic [WIDTH-1:0] wr_data_q;
  logic [WIDTH-1:0] tx_data_q;
  logic             tx_vld_q;
  logic             err_q;

  logic addr_ok;
  assign addr_ok = (RX_P_DATA[WIDTH-1:ADDR] == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      tx_vld_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == WIDTH'(8'hAA))      state_q <= WR_ADDR;
            else if (RX_P_DATA == WIDTH'(8'hBB)) state_q <= RD_ADDR;
            else                                 err_q   <= 1'b1;
          end
        end
        WR_ADDR, RD_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_ok) begin
              addr_q <= RX_P_DATA[ADDR-1:0];
              if (state_q == WR_ADDR) begin
                state_q <= WR_DATA;
              end else begin
                rd_en_q <= 1'b1;
                cnt_q   <= '0;
                state_q <= RD_WAIT;
              end
            end else begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            wr_data_q <= RX_P_DATA;
            wr_en_q   <= 1'b1;
            state_q   <= IDLE;
          end
        end
        RD_WAIT: begin
          if (RX_D_VLD) err_q <= 1'b1;
          // Returning data takes priority over a timeout landing in the same cycle.
          if (RdData_VLD) begin
            tx_data_q <= RdData;
            state_q   <= TX_SEND;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_SEND: begin
          if (RX_D_VLD) err_q <= 1'b1;
          if (!TX_BUSY) begin
            tx_vld_q <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign CMD_ERR   = err_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl: cycle table for write/read/error/reset flows plus
// hand sequences for the read timeout boundary and TX_BUSY back-pressure.
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [7:0] RdData;
  logic       RdData_VLD;
  logic       TX_BUSY;
  logic       WrEn, RdEn, TX_D_VLD, CMD_ERR;
  logic [3:0] Address;
  logic [7:0] WrData, TX_P_DATA;

  int checks = 0;
  int errors = 0;

  reg_cmd_ctrl #(.WIDTH(8), .ADDR(4), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_VLD(RdData_VLD),
    .TX_BUSY(TX_BUSY),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       rxv;
    logic [7:0] rx;
    logic       rdv;
    logic [7:0] rdd;
    logic       busy;
    logic       we;
    logic       re;
    logic [3:0] addr;
    logic [7:0] wd;
    logic [7:0] txd;
    logic       txv;
    logic       err;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  // Drive inputs, take one rising edge, and leave the outputs settled 1ns later.
  task automatic cyc(input logic rst, input logic rxv, input logic [7:0] rx,
                     input logic rdv, input logic [7:0] rdd, input logic busy);
    RST        = rst;
    RX_D_VLD   = rxv;
    RX_P_DATA  = rx;
    RdData_VLD = rdv;
    RdData     = rdd;
    TX_BUSY    = busy;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic we, input logic re, input logic [3:0] a,
                     input logic [7:0] wd, input logic [7:0] txd, input logic txv, input logic err);
    checks++;
    if ({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR} !==
        {we, re, a, wd, txd, txv, err}) begin
      errors++;
      $display("FAIL %s got we=%b re=%b addr=%h wd=%h txd=%h txv=%b err=%b want we=%b re=%b addr=%h wd=%h txd=%h txv=%b err=%b",
               nm, WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR,
               we, re, a, wd, txd, txv, err);
    end
  endtask

  initial begin
    RST = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = '0; RdData_VLD = 1'b0; RdData = '0; TX_BUSY = 1'b0;

    //            rst rxv rx     rdv rdd    bsy  we   re   addr   wd     txd    txv  err
    tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b0}; // reset
    tbl[1]  = '{1'b0,1'b1,8'hAA,1'b0,8'h00,1'b0,1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b0}; // write cmd
    tbl[2]  = '{1'b0,1'b1,8'h05,1'b0,8'h00,1'b0,1'b0,1'b0,4'h5,8'h00,8'h00,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b1,8'h3C,1'b0,8'h00,1'b0,1'b1,1'b0,4'h5,8'h3C,8'h00,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'h5,8'h3C,8'h00,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b1,8'hBB,1'b0,8'h00,1'b0,1'b0,1'b0,4'h5,8'h3C,8'h00,1'b0,1'b0}; // read cmd
    tbl[6]  = '{1'b0,1'b1,8'h02,1'b0,8'h00,1'b0,1'b0,1'b1,4'h2,8'h3C,8'h00,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h00,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,8'h00,1'b1,8'h81,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b1,1'b0};
    tbl[10] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b1,8'h55,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b1}; // bad cmd
    tbl[12] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b0};
    tbl[13] = '{1'b0,1'b1,8'hAA,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b1,8'h15,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b1}; // bad addr
    tbl[15] = '{1'b0,1'b1,8'h3C,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b1}; // now in IDLE
    tbl[16] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b0,8'h00,1'b1,8'h77,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b0}; // stray RdData_VLD
    tbl[18] = '{1'b0,1'b1,8'hAA,1'b0,8'h00,1'b0,1'b0,1'b0,4'h2,8'h3C,8'h81,1'b0,1'b0};
    tbl[19] = '{1'b0,1'b1,8'h05,1'b0,8'h00,1'b0,1'b0,1'b0,4'h5,8'h3C,8'h81,1'b0,1'b0};
    tbl[20] = '{1'b1,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b0}; // mid-cmd reset
    tbl[21] = '{1'b0,1'b1,8'h3C,1'b0,8'h00,1'b0,1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b1};
    tbl[22] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b0};
    tbl[23] = '{1'b0,1'b1,8'hAA,1'b0,8'h00,1'b0,1'b0,1'b0,4'h0,8'h00,8'h00,1'b0,1'b0};
    tbl[24] = '{1'b0,1'b1,8'h0F,1'b0,8'h00,1'b0,1'b0,1'b0,4'hF,8'h00,8'h00,1'b0,1'b0}; // top address
    tbl[25] = '{1'b0,1'b1,8'h10,1'b0,8'h00,1'b0,1'b1,1'b0,4'hF,8'h10,8'h00,1'b0,1'b0};
    tbl[26] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'hF,8'h10,8'h00,1'b0,1'b0};
    tbl[27] = '{1'b0,1'b1,8'hBB,1'b0,8'h00,1'b0,1'b0,1'b0,4'hF,8'h10,8'h00,1'b0,1'b0};
    tbl[28] = '{1'b0,1'b1,8'h10,1'b0,8'h00,1'b0,1'b0,1'b0,4'hF,8'h10,8'h00,1'b0,1'b1}; // first bad addr
    tbl[29] = '{1'b0,1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,4'hF,8'h10,8'h00,1'b0,1'b0};

    for (int i = 0; i < NV; i++) begin
      cyc(tbl[i].rst, tbl[i].rxv, tbl[i].rx, tbl[i].rdv, tbl[i].rdd, tbl[i].busy);
      chk($sformatf("row%0d", i), tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wd,
          tbl[i].txd, tbl[i].txv, tbl[i].err);
    end

    // Read with no returned data: error after the 15th wait cycle, then back in IDLE.
    cyc(0, 1, 8'hBB, 0, 8'h00, 0);
    chk("to_cmd", 0, 0, 4'hF, 8'h10, 8'h00, 0, 0);
    cyc(0, 1, 8'h03, 0, 8'h00, 0);
    chk("to_rden", 0, 1, 4'h3, 8'h10, 8'h00, 0, 0);
    for (int i = 1; i <= 14; i++) begin
      cyc(0, 0, 8'h00, 0, 8'h00, 0);
      chk($sformatf("to_wait%0d", i), 0, 0, 4'h3, 8'h10, 8'h00, 0, 0);
    end
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("to_err", 0, 0, 4'h3, 8'h10, 8'h00, 0, 1);
    cyc(0, 1, 8'hAA, 0, 8'h00, 0);
    chk("to_idle_cmd", 0, 0, 4'h3, 8'h10, 8'h00, 0, 0);
    cyc(0, 1, 8'h04, 0, 8'h00, 0);
    chk("to_idle_addr", 0, 0, 4'h4, 8'h10, 8'h00, 0, 0);
    cyc(0, 1, 8'h99, 0, 8'h00, 0);
    chk("to_idle_wr", 1, 0, 4'h4, 8'h99, 8'h00, 0, 0);

    // Data on the final wait cycle wins; a stray RX byte in RD_WAIT errors without disturbing it.
    cyc(0, 1, 8'hBB, 0, 8'h00, 0);
    chk("edge_cmd", 0, 0, 4'h4, 8'h99, 8'h00, 0, 0);
    cyc(0, 1, 8'h06, 0, 8'h00, 0);
    chk("edge_rden", 0, 1, 4'h6, 8'h99, 8'h00, 0, 0);
    for (int i = 1; i <= 14; i++) begin
      cyc(0, (i == 3), 8'hAA, 0, 8'h00, 0);
      chk($sformatf("edge_wait%0d", i), 0, 0, 4'h6, 8'h99, 8'h00, 0, (i == 3));
    end
    cyc(0, 0, 8'h00, 1, 8'h5A, 0);
    chk("edge_data", 0, 0, 4'h6, 8'h99, 8'h5A, 0, 0);

    // TX back-pressure: hold for 10 busy cycles, RX byte in TX_SEND is an error only.
    for (int j = 0; j < 10; j++) begin
      cyc(0, (j == 5), 8'h55, 0, 8'h00, 1);
      chk($sformatf("busy%0d", j), 0, 0, 4'h6, 8'h99, 8'h5A, 0, (j == 5));
    end
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("busy_send", 0, 0, 4'h6, 8'h99, 8'h5A, 1, 0);
    cyc(0, 0, 8'h00, 0, 8'h00, 0);
    chk("busy_done", 0, 0, 4'h6, 8'h99, 8'h5A, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_cmd_ctrl.md
REG_CMD_CTRL -- requirements
Module: reg_cmd_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data byte width, RX/TX bytes and register data.
REQ-002 Parameter ADDR, default 4: register address width.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles spent waiting for read data.
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 RX_P_DATA  input  WIDTH  received command byte.
REQ-007 RX_D_VLD  input  1  RX_P_DATA valid, one-cycle strobe per byte.
REQ-008 RdData  input  WIDTH  read data returned by the register file.
REQ-009 RdData_VLD  input  1  RdData valid strobe.
REQ-010 TX_BUSY  input  1  transmitter cannot accept a byte.
REQ-011 WrEn  output  1  register write strobe.
REQ-012 RdEn  output  1  register read strobe.
REQ-013 Address  output  ADDR  register address.
REQ-014 WrData  output  WIDTH  register write data.
REQ-015 TX_P_DATA  output  WIDTH  byte to transmit.
REQ-016 TX_D_VLD  output  1  TX_P_DATA valid, one-cycle strobe.
REQ-017 CMD_ERR  output  1  one-cycle error pulse.

Function
REQ-018 All outputs SHALL be registered; FSM states SHALL be IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND.
REQ-019 In IDLE, an RX byte of 0xAA SHALL move the FSM to WR_ADDR, 0xBB SHALL move it to RD_ADDR, and any other byte SHALL pulse CMD_ERR for one cycle while the FSM stays in IDLE.
REQ-020 In WR_ADDR or RD_ADDR, an RX byte whose bits [WIDTH-1:ADDR] are all zero SHALL be latched into Address; otherwise CMD_ERR SHALL pulse and the FSM SHALL return to IDLE.
REQ-021 WR_ADDR with a valid address SHALL go to WR_DATA.
REQ-022 In WR_DATA, an RX byte SHALL drive WrData with that byte and WrEn=1 for exactly one cycle, starting the cycle after the RX_D_VLD cycle; the FSM SHALL then return to IDLE.
REQ-023 RD_ADDR with a valid address SHALL assert RdEn for exactly one cycle, starting the cycle after the RX_D_VLD cycle, and go to RD_WAIT.
REQ-024 WrEn and RdEn SHALL never be asserted in the same cycle.
REQ-025 In RD_WAIT, RdData_VLD=1 SHALL capture RdData into TX_P_DATA and go to TX_SEND.
REQ-026 RD_WAIT SHALL run a wait counter, cleared on entry; if it reaches TIMEOUT without RdData_VLD, CMD_ERR SHALL pulse and the FSM SHALL return to IDLE.
REQ-027 If RdData_VLD arrives in the same cycle the counter reaches TIMEOUT, the data SHALL win and no error SHALL be flagged.
REQ-028 In TX_SEND, while TX_BUSY=1 the FSM SHALL hold with TX_P_DATA stable; on the first cycle with TX_BUSY=0 it SHALL assert TX_D_VLD for one cycle and return to IDLE.
REQ-029 An RX_D_VLD received in RD_WAIT or TX_SEND SHALL be dropped and SHALL pulse CMD_ERR without any state change.
REQ-030 RdData_VLD outside RD_WAIT SHALL be ignored.
REQ-031 WrData, Address and TX_P_DATA SHALL hold their last values between transactions.

Reset
REQ-032 While RST=1 at a clock edge, the FSM SHALL go to IDLE, the wait counter SHALL clear, and all outputs SHALL be 0, including in mid-transaction.
REQ-033 A partially received command SHALL be discarded by reset, and no WrEn, RdEn or TX_D_VLD SHALL follow it.

Verification
REQ-034 Write: RX bytes 0xAA, 0x05, 0x3C -> one WrEn pulse with Address=5 and WrData=0x3C, the cycle after the third byte; CMD_ERR stays 0.
REQ-035 Read: RX bytes 0xBB, 0x02; RdData_VLD=1 with RdData=0x81 two cycles later; TX_BUSY=0 -> one RdEn pulse with Address=2, then TX_D_VLD=1 with TX_P_DATA=0x81.
REQ-036 Read with TX_BUSY held high for 10 cycles after data returns -> TX_D_VLD only after TX_BUSY falls, with TX_P_DATA stable throughout.
REQ-037 Errors: RX byte 0x55 in IDLE -> CMD_ERR pulse; sequence 0xAA, 0x15 -> CMD_ERR pulse with no WrEn; read with no RdData_VLD -> CMD_ERR after 15 wait cycles, FSM back in IDLE.
REQ-038 RST=1 for one cycle between 0xAA, 0x05 and the data byte -> no WrEn, outputs 0, and a following 0x3C alone produces CMD_ERR.
